// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner
//   Time-multiplexes four hex digits onto a common 7-segment bus. Each digit
//   owns a slot of TICK_DIV cycles. The first BLANK cycles of a slot keep the
//   pads dark so the previous digit's segments never ghost onto the next one.
//   New values are taken through a one-deep shadow register. They reach the
//   display only at a frame boundary, so a frame never shows a mix of values.
//
// Ports
//   clk, rst     : clock, asynchronous active-high reset
//   value_in     : four hex digits, digit 0 in bits [3:0] (rightmost)
//   dp_in        : decimal point per digit, 1 = lit
//   value_valid  : offer of value_in/dp_in
//   value_ready  : high when no value is pending, so an offer is accepted
//   blank_lz     : leading-zero suppression enable
//   nibble_out   : digit sent to the external nibble-to-segment decoder
//   seg_in       : active-low segments returned by that decoder (bit 7 unused)
//   seg_out      : active-low segments to the pads, bit 7 = decimal point
//   digit_en_n   : active-low digit enables, bit k drives digit k
//   frame_done   : one-cycle pulse after each complete 4-digit frame
module seven_seg_scanner #(
  parameter int TICK_DIV = 12000,
  parameter int BLANK    = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] value_in,
  input  logic [3:0]  dp_in,
  input  logic        value_valid,
  output logic        value_ready,
  input  logic        blank_lz,
  output logic [3:0]  nibble_out,
  input  logic [7:0]  seg_in,
  output logic [7:0]  seg_out,
  output logic [3:0]  digit_en_n,
  output logic        frame_done
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] CNT_LAST  = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK);

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } slot_state_t;

  slot_state_t   state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic [1:0]    idx;
  logic [15:0]   disp_val;
  logic [3:0]    disp_dp;
  logic [15:0]   shadow_val;
  logic [3:0]    shadow_dp;
  logic          pending;
  logic          lz_slot;
  logic          slot_end;
  logic          frame_end;
  logic          accept;
  logic [3:0]    cur_digit;
  logic          cur_dp;
  logic          suppressed;
  logic          unused_seg_bit;

  // The decoder's bit 7 is replaced by our own decimal point.
  assign unused_seg_bit = seg_in[7];

  assign slot_end    = (cnt == CNT_LAST);
  assign frame_end   = slot_end && (idx == 2'd3);
  assign accept      = value_valid && !pending;
  assign value_ready = !pending;
  assign cnt_next    = slot_end ? '0 : cnt + 1'b1;

  // Digit selection and leading-zero suppression for the current slot. A
  // digit is dark when it and every more-significant digit are zero. Digit 0
  // always shows, so a zero value still displays a single "0".
  always_comb begin
    cur_digit  = disp_val[3:0];
    cur_dp     = disp_dp[0];
    suppressed = 1'b0;
    case (idx)
      2'd0: begin
        cur_digit = disp_val[3:0];
        cur_dp    = disp_dp[0];
      end
      2'd1: begin
        cur_digit  = disp_val[7:4];
        cur_dp     = disp_dp[1];
        suppressed = lz_slot && (disp_val[15:4] == 12'h000);
      end
      2'd2: begin
        cur_digit  = disp_val[11:8];
        cur_dp     = disp_dp[2];
        suppressed = lz_slot && (disp_val[15:8] == 8'h00);
      end
      default: begin
        cur_digit  = disp_val[15:12];
        cur_dp     = disp_dp[3];
        suppressed = lz_slot && (disp_val[15:12] == 4'h0);
      end
    endcase
  end

  // Slot timing and the BLANK/SHOW FSM. The state is computed from the
  // counter's next value, so it always matches the counter position.
  // blank_lz is latched at the end of each slot. A change therefore never
  // cuts a slot in half.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      idx     <= 2'd0;
      state   <= ST_BLANK;
      lz_slot <= 1'b0;
    end else begin
      cnt   <= cnt_next;
      state <= (cnt_next >= BLANK_END) ? ST_SHOW : ST_BLANK;
      if (slot_end) begin
        idx     <= idx + 2'd1;
        lz_slot <= blank_lz;
      end
    end
  end

  // Shadow handshake. The shadow copies into the display only at a frame
  // boundary. An offer accepted on the boundary cycle itself sees
  // pending = 0, so the boundary does not copy. That offer stays pending
  // until the following boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp_val   <= 16'h0000;
      disp_dp    <= 4'h0;
      shadow_val <= 16'h0000;
      shadow_dp  <= 4'h0;
      pending    <= 1'b0;
    end else begin
      if (frame_end && pending) begin
        disp_val <= shadow_val;
        disp_dp  <= shadow_dp;
        pending  <= 1'b0;
      end else if (accept) begin
        shadow_val <= value_in;
        shadow_dp  <= dp_in;
        pending    <= 1'b1;
      end
    end
  end

  // Registered pad drive, one cycle behind the FSM. nibble_out is refreshed
  // every cycle. The external decoder therefore settles during the blank
  // window, before SHOW uses its result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nibble_out <= 4'h0;
      seg_out    <= 8'hFF;
      digit_en_n <= 4'hF;
      frame_done <= 1'b0;
    end else begin
      nibble_out <= cur_digit;
      frame_done <= frame_end;
      if (state == ST_SHOW && !suppressed) begin
        seg_out    <= {~cur_dp, seg_in[6:0]};
        digit_en_n <= ~(4'b0001 << idx);
      end else begin
        seg_out    <= 8'hFF;
        digit_en_n <= 4'hF;
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// tb_seven_seg_scanner
//   Drives the scanner with directed and random offers. Every cycle, the DUT
//   outputs are compared against a frame-level model: cycle t after reset
//   is slot position t % TICK_DIV of digit (t / TICK_DIV) % 4. Hand-computed
//   literal checks pin the scan sequence, handshake, collision, suppression
//   and reset cases.
module tb_seven_seg_scanner;

  localparam int TD = 8;
  localparam int BL = 2;
  localparam int FRAME = 4 * TD;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] value_in = 16'h0000;
  logic [3:0]  dp_in = 4'h0;
  logic        value_valid = 1'b0;
  logic        value_ready;
  logic        blank_lz = 1'b0;
  logic [3:0]  nibble_out;
  logic [7:0]  seg_in;
  logic [7:0]  seg_out;
  logic [3:0]  digit_en_n;
  logic        frame_done;
  logic        seg_junk = 1'b0;

  int compare_count = 0;
  int mismatch_count = 0;
  logic check_en = 1'b0;

  // Model state.
  int          m_t = 0;
  logic [15:0] m_disp = 16'h0000;
  logic [3:0]  m_dp = 4'h0;
  logic [15:0] m_shadow = 16'h0000;
  logic [3:0]  m_shadow_dp = 4'h0;
  logic        m_pending = 1'b0;
  logic        m_lz = 1'b0;
  logic [3:0]  exp_nib = 4'h0;
  logic [7:0]  exp_seg = 8'hFF;
  logic [3:0]  exp_en = 4'hF;
  logic        exp_fd = 1'b0;
  logic        exp_ready = 1'b1;

  seven_seg_scanner #(.TICK_DIV(TD), .BLANK(BL)) dut (
    .clk(clk),
    .rst(rst),
    .value_in(value_in),
    .dp_in(dp_in),
    .value_valid(value_valid),
    .value_ready(value_ready),
    .blank_lz(blank_lz),
    .nibble_out(nibble_out),
    .seg_in(seg_in),
    .seg_out(seg_out),
    .digit_en_n(digit_en_n),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Active-low gfedcba hex font for the external decoder.
  function automatic logic [6:0] hexseg(input logic [3:0] n);
    case (n)
      4'h0: hexseg = 7'h40;  4'h1: hexseg = 7'h79;
      4'h2: hexseg = 7'h24;  4'h3: hexseg = 7'h30;
      4'h4: hexseg = 7'h19;  4'h5: hexseg = 7'h12;
      4'h6: hexseg = 7'h02;  4'h7: hexseg = 7'h78;
      4'h8: hexseg = 7'h00;  4'h9: hexseg = 7'h10;
      4'hA: hexseg = 7'h08;  4'hB: hexseg = 7'h03;
      4'hC: hexseg = 7'h46;  4'hD: hexseg = 7'h21;
      4'hE: hexseg = 7'h06;  default: hexseg = 7'h0E;
    endcase
  endfunction

  // The decoder's bit 7 carries random junk that the scanner must ignore.
  assign seg_in = {seg_junk, hexseg(nibble_out)};

  function automatic logic lz_dark(input logic [15:0] v, input int k, input logic lz);
    lz_dark = lz && (k > 0) && ((v >> (4 * k)) == 16'h0000);
  endfunction

  // Reference model. Expected outputs after each edge follow from the slot
  // position and the digit reached at that edge.
  initial begin
    int pos;
    int d;
    logic lit;
    logic [3:0] dig;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_t = 0; m_disp = 16'h0000; m_dp = 4'h0; m_pending = 1'b0; m_lz = 1'b0;
        exp_nib = 4'h0; exp_seg = 8'hFF; exp_en = 4'hF; exp_fd = 1'b0; exp_ready = 1'b1;
      end else begin
        pos = m_t % TD;
        d = (m_t / TD) % 4;
        dig = m_disp[4*d +: 4];
        lit = (pos >= BL) && !lz_dark(m_disp, d, m_lz);
        exp_nib = dig;
        exp_seg = lit ? {~m_dp[d], hexseg(dig)} : 8'hFF;
        exp_en = lit ? ~(4'b0001 << d) : 4'hF;
        exp_fd = (pos == TD - 1) && (d == 3);
        if (exp_fd && m_pending) begin
          m_disp = m_shadow; m_dp = m_shadow_dp; m_pending = 1'b0;
        end else if (value_valid && !m_pending) begin
          m_shadow = value_in; m_shadow_dp = dp_in; m_pending = 1'b1;
        end
        if (pos == TD - 1) m_lz = blank_lz;
        m_t = m_t + 1;
        exp_ready = !m_pending;
      end
    end
  end

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    compare_count++;
    if (actual !== expected) begin
      mismatch_count++;
      $display("[TB] FAIL %s: got %0h expected %0h (t=%0d)", name, actual, expected, m_t);
    end
  endtask

  // Per-cycle comparison on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (check_en) begin
        check_output("nibble_out", 32'(nibble_out), 32'(exp_nib));
        check_output("seg_out", 32'(seg_out), 32'(exp_seg));
        check_output("digit_en_n", 32'(digit_en_n), 32'(exp_en));
        check_output("frame_done", 32'(frame_done), 32'(exp_fd));
        check_output("value_ready", 32'(value_ready), 32'(exp_ready));
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic [15:0] v, input logic [3:0] dp);
    value_in = v;
    dp_in = dp;
    value_valid = 1'b1;
    step();
    value_valid = 1'b0;
    value_in = 16'($urandom);
  endtask

  task automatic wait_slot(input int d, input int pos);
    int n = 0;
    while (!((m_t % TD) == pos && ((m_t / TD) % 4) == d) && n < 200) begin
      step();
      n++;
    end
    if (n >= 200) begin
      compare_count++;
      mismatch_count++;
      $display("[TB] FAIL wait_slot timeout: digit %0d pos %0d", d, pos);
    end
  endtask

  initial begin
    #1 rst = 1'b1;
    step();
    check_en = 1'b1;
    step();
    check_output("reset seg_out", 32'(seg_out), 32'hFF);
    check_output("reset digit_en_n", 32'(digit_en_n), 32'hF);
    check_output("reset value_ready", 32'(value_ready), 32'h1);
    check_output("reset frame_done", 32'(frame_done), 32'h0);
    rst = 1'b0;

    // Scan after reset: F,F,E x6, F,F,D x6, ...
    step();
    check_output("scan t1 en", 32'(digit_en_n), 32'hF);
    repeat (2) step();
    check_output("scan t3 en", 32'(digit_en_n), 32'hE);
    repeat (8) step();
    check_output("scan t11 en", 32'(digit_en_n), 32'hD);
    repeat (16) step();
    check_output("scan t27 en", 32'(digit_en_n), 32'h7);
    repeat (4) step();
    check_output("scan t31 frame_done", 32'(frame_done), 32'h0);
    step();
    check_output("scan t32 frame_done", 32'(frame_done), 32'h1);

    // Value update mid-frame, then a back-pressured second offer.
    wait_slot(1, 3);
    apply_stimulus(16'h12AF, 4'b0100);
    check_output("ready after accept", 32'(value_ready), 32'h0);
    value_in = 16'h5555;
    dp_in = 4'hF;
    value_valid = 1'b1;
    repeat (3) step();
    value_valid = 1'b0;
    check_output("ready while pending", 32'(value_ready), 32'h0);
    wait_slot(3, 7);
    check_output("ready before boundary", 32'(value_ready), 32'h0);
    step();
    check_output("ready after boundary", 32'(value_ready), 32'h1);
    wait_slot(0, 5);
    check_output("upd digit0 nibble", 32'(nibble_out), 32'hF);
    check_output("upd digit0 dp", 32'(seg_out[7]), 32'h1);
    wait_slot(1, 5);
    check_output("upd digit1 nibble", 32'(nibble_out), 32'hA);
    wait_slot(2, 5);
    check_output("upd digit2 nibble", 32'(nibble_out), 32'h2);
    check_output("upd digit2 dp", 32'(seg_out[7]), 32'h0);
    wait_slot(3, 5);
    check_output("upd digit3 nibble", 32'(nibble_out), 32'h1);

    // Accept on the boundary cycle: shown one full frame later.
    blank_lz = 1'b1;
    wait_slot(3, 7);
    apply_stimulus(16'h0042, 4'h0);
    check_output("collision ready", 32'(value_ready), 32'h0);
    wait_slot(3, 5);
    check_output("collision old digit3", 32'(nibble_out), 32'h1);
    wait_slot(3, 7);
    step();
    check_output("collision ready later", 32'(value_ready), 32'h1);

    // Leading-zero suppression of 0042.
    wait_slot(0, 5);
    check_output("lz digit0 en", 32'(digit_en_n), 32'hE);
    check_output("lz digit0 nibble", 32'(nibble_out), 32'h2);
    wait_slot(1, 5);
    check_output("lz digit1 en", 32'(digit_en_n), 32'hD);
    check_output("lz digit1 nibble", 32'(nibble_out), 32'h4);
    wait_slot(2, 5);
    check_output("lz digit2 en", 32'(digit_en_n), 32'hF);
    check_output("lz digit2 seg", 32'(seg_out), 32'hFF);
    wait_slot(3, 5);
    check_output("lz digit3 en", 32'(digit_en_n), 32'hF);
    check_output("lz digit3 seg", 32'(seg_out), 32'hFF);

    // All-zero value: only digit 0 lit.
    apply_stimulus(16'h0000, 4'h0);
    wait_slot(0, 5);
    check_output("zero digit0 en", 32'(digit_en_n), 32'hE);
    check_output("zero digit0 seg", 32'(seg_out), 32'hC0);
    wait_slot(1, 5);
    check_output("zero digit1 en", 32'(digit_en_n), 32'hF);
    wait_slot(2, 5);
    check_output("zero digit2 en", 32'(digit_en_n), 32'hF);
    wait_slot(3, 5);
    check_output("zero digit3 en", 32'(digit_en_n), 32'hF);
    blank_lz = 1'b0;

    // Random offers, dp, suppression toggles and decoder junk bit.
    repeat (2500) begin
      value_valid = ($urandom_range(0, 3) == 0);
      value_in = 16'($urandom);
      dp_in = 4'($urandom);
      if ($urandom_range(0, 63) == 0) blank_lz = ~blank_lz;
      seg_junk = 1'($urandom);
      step();
    end
    value_valid = 1'b0;

    // Reset during digit 2 SHOW with a value pending.
    wait_slot(1, 0);
    apply_stimulus(16'hABCD, 4'hF);
    check_output("pre-reset pending", 32'(value_ready), 32'h0);
    wait_slot(2, 5);
    rst = 1'b1;
    #1;
    check_output("async reset seg", 32'(seg_out), 32'hFF);
    check_output("async reset en", 32'(digit_en_n), 32'hF);
    check_output("async reset ready", 32'(value_ready), 32'h1);
    check_output("async reset nibble", 32'(nibble_out), 32'h0);
    check_output("async reset frame_done", 32'(frame_done), 32'h0);
    repeat (2) step();
    rst = 1'b0;
    check_output("post-reset ready", 32'(value_ready), 32'h1);
    repeat (3) step();
    check_output("post-reset t3 en", 32'(digit_en_n), 32'hE);
    repeat (40) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
    $finish;
  end

endmodule
